// File: rtl/mem_access_unit_if.sv
// Data-bus interface between the memory access unit and an SRAM-like bus.
// The master drives the request side; the slave answers with addr_ok/data_ok.
interface mem_access_unit_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic          data_req;
  logic          data_wr;
  logic [1:0]    data_size;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_addr_ok;
  logic          data_data_ok;
  logic [DW-1:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns a decoded access into one registered
// req/addr_ok/data_ok bus transaction, stalls the pipeline until it completes,
// and returns aligned, extended load data. Misaligned accesses raise an
// address exception and never reach the bus.
module mem_access_unit #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          memen,
  input  logic          memwrite,
  input  logic [1:0]    memsize,
  input  logic          memsign,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          flush,
  output logic          stall,
  output logic [DW-1:0] rdata,
  output logic          adel,
  output logic          ades,
  mem_access_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_e;

  state_e        state_q, state_d;
  logic          cancel_q, cancel_d;
  logic          sign_q, sign_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          req_q, req_d;
  logic          wr_q, wr_d;
  logic [1:0]    size_q, size_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          misalign;
  logic          go;
  logic          complete;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [DW-1:0] load_ext;
  logic [DW-1:0] wdata_rep;

  assign misalign = ((memsize == 2'b01) & addr[0]) | (memsize[1] & (addr[1:0] != 2'b00));
  assign adel     = memen & ~memwrite & misalign;
  assign ades     = memen & memwrite & misalign;
  assign go       = memen & ~misalign & ~flush;
  assign stall    = ((state_q == IDLE) & go) | (state_q == ADDR) | (state_q == DATA);

  assign rdata          = rdata_q;
  assign bus.data_req   = req_q;
  assign bus.data_wr    = wr_q;
  assign bus.data_size  = size_q;
  assign bus.data_addr  = addr_q;
  assign bus.data_wdata = wdata_q;

  // Replicate store data across the byte lanes the access touches.
  always_comb begin
    wdata_rep = wdata;
    case (memsize)
      2'b00:   wdata_rep = {4{wdata[7:0]}};
      2'b01:   wdata_rep = {2{wdata[15:0]}};
      default: wdata_rep = wdata;
    endcase
  end

  // Select the addressed lane of bus read data and extend it to full width.
  always_comb begin
    byte_sel = bus.data_rdata[7:0];
    case (addr_q[1:0])
      2'd0: byte_sel = bus.data_rdata[7:0];
      2'd1: byte_sel = bus.data_rdata[15:8];
      2'd2: byte_sel = bus.data_rdata[23:16];
      2'd3: byte_sel = bus.data_rdata[31:24];
      default: byte_sel = bus.data_rdata[7:0];
    endcase
    half_sel = addr_q[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{sign_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{sign_q & half_sel[15]}}, half_sel};
      default: load_ext = bus.data_rdata;
    endcase
  end

  // Transaction FSM next-state and bus/result register updates.
  always_comb begin
    state_d  = state_q;
    cancel_d = cancel_q;
    sign_d   = sign_q;
    rdata_d  = rdata_q;
    req_d    = req_q;
    wr_d     = wr_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d  = ADDR;
          req_d    = 1'b1;
          wr_d     = memwrite;
          size_d   = memsize;
          addr_d   = addr;
          wdata_d  = wdata_rep;
          sign_d   = memsign;
          cancel_d = 1'b0;
        end
      end
      ADDR: begin
        if (flush) cancel_d = 1'b1;
        if (bus.data_addr_ok) begin
          req_d = 1'b0;
          if (bus.data_data_ok) complete = 1'b1;
          else                  state_d  = DATA;
        end
      end
      DATA: begin
        if (flush) cancel_d = 1'b1;
        if (bus.data_data_ok) complete = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A flush landing on the completion cycle itself cancels as well; a
    // cancelled access skips DONE so the pipeline never sees it retire.
    if (complete) begin
      cancel_d = 1'b0;
      if (cancel_q | flush) begin
        state_d = IDLE;
      end else begin
        state_d = DONE;
        if (!wr_q) rdata_d = load_ext;
      end
    end
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cancel_q <= 1'b0;
      sign_q   <= 1'b0;
      rdata_q  <= '0;
      req_q    <= 1'b0;
      wr_q     <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      sign_q   <= sign_d;
      rdata_q  <= rdata_d;
      req_q    <= req_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

endmodule
